// File: rtl/sprite_renderer.sv
// Draws one of NUM_SPRITES packed ROM sprites at an offset, with index transparency
// and a blinking highlight border. The pipeline is aligned to the ROM read latency.
module sprite_renderer #(
  parameter int              SPRITE_W        = 55,
  parameter int              SPRITE_H        = 55,
  parameter int              NUM_SPRITES     = 12,
  parameter int              IDX_W           = 4,
  parameter int              ROM_LATENCY     = 1,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = '0,
  parameter int              BORDER_W        = 2,
  parameter int              BLINK_FRAMES    = 30,
  parameter logic [11:0]     HIGHLIGHT_RGB   = 12'hFF0,
  localparam int             SEL_W           = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int             ADDR_W          = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        offsetX,
  input  logic [9:0]        offsetY,
  input  logic [SEL_W-1:0]  sprite_sel,
  input  logic              selected,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on,
  output logic              border_on
);

  localparam logic [9:0]        W10    = 10'(SPRITE_W);
  localparam logic [9:0]        H10    = 10'(SPRITE_H);
  localparam logic [9:0]        BW10   = 10'(BORDER_W);
  localparam logic [9:0]        W_IN   = 10'(SPRITE_W - BORDER_W);
  localparam logic [9:0]        H_IN   = 10'(SPRITE_H - BORDER_W);
  localparam logic [SEL_W:0]    NSPR   = (SEL_W + 1)'(NUM_SPRITES);
  localparam logic [ADDR_W-1:0] FRAME  = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SPRITE_W);
  localparam int                CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(BLINK_FRAMES - 1);

  logic [9:0]        lx, ly;
  logic              in_box, valid, border;
  logic [ADDR_W-1:0] pix_addr;

  assign lx = DrawX - offsetX;
  assign ly = DrawY - offsetY;

  // The >= guards reject pixels left of/above the sprite before the wrapped lx/ly is trusted.
  assign in_box = (DrawX >= offsetX) && (DrawY >= offsetY) && (lx < W10) && (ly < H10);
  assign valid  = in_box && ({1'b0, sprite_sel} < NSPR);
  assign border = valid && ((lx < BW10) || (lx >= W_IN) || (ly < BW10) || (ly >= H_IN));

  assign pix_addr = ADDR_W'(sprite_sel) * FRAME + ADDR_W'(ly) * STRIDE + ADDR_W'(lx);

  // Bit 0 is loaded alongside rom_addr; bit ROM_LATENCY lines up with valid rom_q.
  logic [ROM_LATENCY:0] v_pipe, b_pipe, s_pipe;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      v_pipe   <= '0;
      b_pipe   <= '0;
      s_pipe   <= '0;
    end else begin
      rom_addr <= valid ? pix_addr : '0;
      v_pipe   <= {v_pipe[ROM_LATENCY-1:0], valid};
      b_pipe   <= {b_pipe[ROM_LATENCY-1:0], border};
      s_pipe   <= {s_pipe[ROM_LATENCY-1:0], selected};
    end
  end

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign pal_idx = rom_q;

  logic        nxt_on, nxt_border;
  logic [11:0] nxt_rgb;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    nxt_on     = 1'b0;
    nxt_border = 1'b0;
    nxt_rgb    = '0;
    if (v_pipe[ROM_LATENCY] && b_pipe[ROM_LATENCY] && s_pipe[ROM_LATENCY] && blink_phase) begin
      nxt_on     = 1'b1;
      nxt_border = 1'b1;
      nxt_rgb    = HIGHLIGHT_RGB;
    end else if (v_pipe[ROM_LATENCY] && (rom_q != TRANSPARENT_IDX)) begin
      nxt_on  = 1'b1;
      nxt_rgb = {pal_red, pal_green, pal_blue};
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      sprite_on <= 1'b0;
      border_on <= 1'b0;
    end else begin
      {red, green, blue} <= nxt_rgb;
      sprite_on          <= nxt_on;
      border_on          <= nxt_border;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: two instances (ROM latency 1 and 3) share stimulus and are
// compared every edge against a pixel model computed from recorded input history.
module tb_sprite_renderer;

  localparam int SW   = 55;
  localparam int SH   = 55;
  localparam int NSPR = 12;
  localparam int BF   = 2;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       selected = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, offsetX = '0, offsetY = '0;
  logic [3:0] sprite_sel = '0;

  logic [15:0] rom_addr_a, rom_addr_b;
  logic [3:0]  rom_q_a, rom_q_b, pal_idx_a, pal_idx_b;
  logic [3:0]  pr_a, pg_a, pb_a, pr_b, pg_b, pb_b;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic        sprite_on_a, border_on_a, sprite_on_b, border_on_b;
  logic [3:0]  rb1, rb2;

  int tests = 0;
  int fails = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_renderer #(.ROM_LATENCY(1), .BLINK_FRAMES(BF)) dut_a (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .offsetX(offsetX), .offsetY(offsetY),
    .sprite_sel(sprite_sel), .selected(selected),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a), .pal_idx(pal_idx_a),
    .pal_red(pr_a), .pal_green(pg_a), .pal_blue(pb_a),
    .red(red_a), .green(green_a), .blue(blue_a),
    .sprite_on(sprite_on_a), .border_on(border_on_a)
  );

  sprite_renderer #(.ROM_LATENCY(3), .BLINK_FRAMES(BF)) dut_b (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .offsetX(offsetX), .offsetY(offsetY),
    .sprite_sel(sprite_sel), .selected(selected),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b), .pal_idx(pal_idx_b),
    .pal_red(pr_b), .pal_green(pg_b), .pal_blue(pb_b),
    .red(red_b), .green(green_b), .blue(blue_b),
    .sprite_on(sprite_on_b), .border_on(border_on_b)
  );

  // ROM contents: a hash, with two fixed entries in sprite 3 at (20,20)=0 and (21,20)=5.
  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'd10195) return 4'd0;
    if (a == 16'd10196) return 4'd5;
    h = (a * 16'd7) ^ (a >> 5);
    return h[3:0];
  endfunction

  function automatic logic [11:0] pal_fn(input logic [3:0] i);
    return {i, i ^ 4'h5, ~i};
  endfunction

  always @(posedge vga_clk) rom_q_a <= rom_fn(rom_addr_a);
  always @(posedge vga_clk) begin
    rb1     <= rom_fn(rom_addr_b);
    rb2     <= rb1;
    rom_q_b <= rb2;
  end

  assign {pr_a, pg_a, pb_a} = pal_fn(pal_idx_a);
  assign {pr_b, pg_b, pb_b} = pal_fn(pal_idx_b);

  typedef struct {
    int dx, dy, ox, oy, sel;
    bit sl, fs, rst;
  } rec_t;

  rec_t hist[$];
  int   last_rst = -1000;

  function automatic int model_addr(input rec_t r, output bit v, output bit brd);
    int lx, ly;
    lx  = r.dx - r.ox;
    ly  = r.dy - r.oy;
    v   = (r.dx >= r.ox) && (r.dy >= r.oy) && (lx < SW) && (ly < SH) && (r.sel < NSPR);
    brd = v && (lx < 2 || lx >= SW - 2 || ly < 2 || ly >= SH - 2);
    return v ? r.sel * SW * SH + ly * SW + lx : 0;
  endfunction

  // Expected {sprite_on, border_on, rgb} just after edge k for a DUT of ROM latency lat.
  function automatic logic [13:0] exp_pix(input int k, input int lat);
    int src, pulses, a;
    bit v, brd, ph;
    logic [3:0] idx;
    src    = k - lat - 1;
    pulses = 0;
    if (src < 0 || src <= last_rst) return '0;
    for (int j = last_rst + 1; j < k; j++) if (hist[j].fs) pulses++;
    ph = ((pulses / BF) % 2) == 0;
    a  = model_addr(hist[src], v, brd);
    if (v && brd && hist[src].sl && ph) return {2'b11, 12'hFF0};
    idx = rom_fn(16'(a));
    if (v && idx != 4'd0) return {2'b10, pal_fn(idx)};
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int k, a;
    bit v, b;
    @(posedge vga_clk);
    hist.push_back('{int'(DrawX), int'(DrawY), int'(offsetX), int'(offsetY), int'(sprite_sel),
                     selected, frame_start, reset});
    k = hist.size() - 1;
    if (reset) last_rst = k;
    #1;
    a = reset ? 0 : model_addr(hist[k], v, b);
    chk("addr_a", 32'(rom_addr_a), 32'(a));
    chk("addr_b", 32'(rom_addr_b), 32'(a));
    chk("pix_a", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}), 32'(exp_pix(k, 1)));
    chk("pix_b", 32'({sprite_on_b, border_on_b, red_b, green_b, blue_b}), 32'(exp_pix(k, 3)));
  endtask

  task automatic set_px(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  initial begin
    repeat (3) step();
    chk("reset_addr", 32'(rom_addr_a), 32'd0);
    chk("reset_on", 32'({sprite_on_b, border_on_b}), 32'd0);
    reset = 1'b0;

    offsetX = 10'd100; offsetY = 10'd50; sprite_sel = 4'd3; selected = 1'b0;
    set_px(154, 104); step();
    chk("addr_12099", 32'(rom_addr_a), 32'd12099);
    set_px(155, 104); step();
    chk("addr_lx55", 32'(rom_addr_a), 32'd0);
    set_px(99, 104); step();
    chk("on_corner", 32'(sprite_on_a), 32'd1);
    chk("addr_wrap", 32'(rom_addr_a), 32'd0);
    set_px(120, 70); step();
    chk("off_lx55", 32'(sprite_on_a), 32'd0);
    set_px(121, 70); step();
    chk("off_wrap", 32'(sprite_on_a), 32'd0);
    step();
    chk("transparent", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}), 32'd0);
    step();
    chk("opaque_idx5", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}),
        32'({2'b10, 12'h50A}));

    selected = 1'b1;
    set_px(100, 70);
    repeat (3) step();
    chk("hl_on", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}), 32'({2'b11, 12'hFF0}));
    repeat (2) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
    step();
    chk("hl_blink_off", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}),
        32'({2'b10, pal_fn(rom_fn(16'd10175))}));
    repeat (2) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
    step();
    chk("hl_back", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}), 32'({2'b11, 12'hFF0}));

    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        offsetX = 10'($urandom_range(0, 1023));
        offsetY = 10'($urandom_range(0, 1023));
      end
      DrawX       = offsetX + 10'($urandom_range(0, 62)) - 10'd4;
      DrawY       = offsetY + 10'($urandom_range(0, 62)) - 10'd4;
      sprite_sel  = 4'($urandom_range(0, 15));
      selected    = 1'($urandom_range(0, 1));
      frame_start = ($urandom_range(0, 7) == 0);
      step();
    end
    frame_start = 1'b0;

    offsetX = 10'd100; offsetY = 10'd50; sprite_sel = 4'd7; selected = 1'b1;
    for (int x = 0; x < 200; x++) begin
      set_px(x, 60);
      step();
    end

    selected = 1'b0; sprite_sel = 4'd3;
    set_px(121, 70);
    repeat (5) step();
    chk("pre_rst_a", 32'(sprite_on_a), 32'd1);
    chk("pre_rst_b", 32'(sprite_on_b), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_a", 32'({sprite_on_a, border_on_a, red_a, green_a, blue_a}), 32'd0);
    chk("async_rst_b", 32'({sprite_on_b, border_on_b, red_b, green_b, blue_b}), 32'd0);
    chk("async_rst_addr", 32'(rom_addr_b), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();

    selected = 1'b1;
    set_px(100, 70);
    frame_start = 1'b1; step();
    frame_start = 1'b0;
    repeat (5) step();
    chk("hl_after_rst_a", 32'({sprite_on_a, border_on_a}), 32'd3);
    chk("hl_after_rst_b", 32'({sprite_on_b, border_on_b}), 32'd3);
    frame_start = 1'b1; step();
    frame_start = 1'b0;
    repeat (5) step();
    chk("blink_after_rst", 32'(border_on_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
